// File: rtl/shot_collision_detector.sv
// Per-frame shot collision detector: gathers shot/enemy/tower pixel overlaps during a frame
// and reports them as one-cycle pulses in the cycle after the frame-closing startOfFrame.
module shot_collision_detector #(
    parameter int NUM_ENEMIES = 4,
    parameter int SCORE_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   pause,
    input  logic [2:0]             shotDrawingRequests,
    input  logic [NUM_ENEMIES-1:0] enemyDrawingRequests,
    input  logic                   towerDrawingRequest,
    output logic [2:0]             shotEnemyCollision,
    output logic [2:0]             shotTowerCollision,
    output logic [NUM_ENEMIES-1:0] enemyHit,
    output logic [SCORE_WIDTH-1:0] hitCount
);

    localparam logic [1:0] SYNC    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] REPORT  = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [2:0]             pend_e_q, pend_e_d;
    logic [2:0]             pend_t_q, pend_t_d;
    logic [NUM_ENEMIES-1:0] pend_h_q, pend_h_d;
    logic [2:0]             seen_q, seen_d;
    logic [2:0]             snap_e_q, snap_e_d;
    logic [2:0]             snap_t_q, snap_t_d;
    logic [NUM_ENEMIES-1:0] snap_h_q, snap_h_d;
    logic [2:0]             snap_seen_q, snap_seen_d;
    logic [2:0]             armed_q, armed_d;
    logic [SCORE_WIDTH-1:0] hit_count_q, hit_count_d;

    logic                   in_report;
    logic [2:0]             report_e;
    logic [2:0]             report_t;
    logic [1:0]             hit_inc;
    logic [SCORE_WIDTH+1:0] hit_sum;
    logic [SCORE_WIDTH+1:0] hit_max;

    assign in_report = (state_q == REPORT);
    assign report_e  = snap_e_q & armed_q;
    assign report_t  = snap_t_q & ~snap_e_q & armed_q;

    assign shotEnemyCollision = in_report ? report_e : 3'b000;
    assign shotTowerCollision = in_report ? report_t : 3'b000;
    assign enemyHit           = in_report ? snap_h_q : '0;
    assign hitCount           = hit_count_q;

    // Saturating score: a wider sum is compared against the all-ones score value.
    assign hit_inc = {1'b0, report_e[0]} + {1'b0, report_e[1]} + {1'b0, report_e[2]};
    assign hit_sum = {2'b00, hit_count_q} + {{SCORE_WIDTH{1'b0}}, hit_inc};
    assign hit_max = {2'b00, {SCORE_WIDTH{1'b1}}};

    always_comb begin
        state_d     = state_q;
        pend_e_d    = pend_e_q;
        pend_t_d    = pend_t_q;
        pend_h_d    = pend_h_q;
        seen_d      = seen_q;
        snap_e_d    = snap_e_q;
        snap_t_d    = snap_t_q;
        snap_h_d    = snap_h_q;
        snap_seen_d = snap_seen_q;
        armed_d     = armed_q;
        hit_count_d = hit_count_q;

        case (state_q)
            SYNC: begin
                if (startOfFrame) begin
                    state_d  = COLLECT;
                    pend_e_d = 3'b000;
                    pend_t_d = 3'b000;
                    pend_h_d = '0;
                    seen_d   = 3'b000;
                end
            end
            COLLECT: begin
                if (startOfFrame) begin
                    state_d     = REPORT;
                    snap_e_d    = pend_e_q;
                    snap_t_d    = pend_t_q;
                    snap_h_d    = pend_h_q;
                    snap_seen_d = seen_q;
                    pend_e_d    = 3'b000;
                    pend_t_d    = 3'b000;
                    pend_h_d    = '0;
                    seen_d      = 3'b000;
                end else begin
                    seen_d = seen_q | shotDrawingRequests;
                    if (!pause) begin
                        pend_e_d = pend_e_q | (shotDrawingRequests & {3{|enemyDrawingRequests}});
                        pend_t_d = pend_t_q | (shotDrawingRequests & {3{towerDrawingRequest}});
                        pend_h_d = pend_h_q | (enemyDrawingRequests &
                                   {NUM_ENEMIES{|(shotDrawingRequests & armed_q)}});
                    end
                end
            end
            REPORT: begin
                // A reporting shot disarms; a slot absent for a whole frame was re-fired.
                state_d = COLLECT;
                armed_d = (armed_q & ~(report_e | report_t)) | ~snap_seen_q;
                hit_count_d = (hit_sum > hit_max) ? {SCORE_WIDTH{1'b1}} : hit_sum[SCORE_WIDTH-1:0];
            end
            default: begin
                state_d = SYNC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= SYNC;
            pend_e_q    <= 3'b000;
            pend_t_q    <= 3'b000;
            pend_h_q    <= '0;
            seen_q      <= 3'b000;
            snap_e_q    <= 3'b000;
            snap_t_q    <= 3'b000;
            snap_h_q    <= '0;
            snap_seen_q <= 3'b000;
            armed_q     <= 3'b111;
            hit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_e_q    <= pend_e_d;
            pend_t_q    <= pend_t_d;
            pend_h_q    <= pend_h_d;
            seen_q      <= seen_d;
            snap_e_q    <= snap_e_d;
            snap_t_q    <= snap_t_d;
            snap_h_q    <= snap_h_d;
            snap_seen_q <= snap_seen_d;
            armed_q     <= armed_d;
            hit_count_q <= hit_count_d;
        end
    end

endmodule

// File: tb/tb_shot_collision_detector.sv
// Directed bench for shot_collision_detector: a vector table for frame-level behaviour
// plus hand-written sequences for score saturation and mid-frame reset.
module tb_shot_collision_detector;

    logic       clk;
    logic       resetN;
    logic       startOfFrame;
    logic       pause;
    logic [2:0] shotDrawingRequests;
    logic [3:0] enemyDrawingRequests;
    logic       towerDrawingRequest;
    logic [2:0] shotEnemyCollision;
    logic [2:0] shotTowerCollision;
    logic [3:0] enemyHit;
    logic [7:0] hitCount;

    typedef struct {
        logic       sof;
        logic       pause;
        logic [2:0] shot;
        logic [3:0] enemy;
        logic       tower;
        logic [2:0] exp_se;
        logic [2:0] exp_st;
        logic [3:0] exp_eh;
        logic       chk_hc;
        logic [7:0] exp_hc;
    } vec_t;

    vec_t vecs[$];
    int   tests_run;
    int   tests_failed;
    int   exp_count;

    shot_collision_detector #(
        .NUM_ENEMIES(4),
        .SCORE_WIDTH(8)
    ) dut (
        .clk                 (clk),
        .resetN              (resetN),
        .startOfFrame        (startOfFrame),
        .pause               (pause),
        .shotDrawingRequests (shotDrawingRequests),
        .enemyDrawingRequests(enemyDrawingRequests),
        .towerDrawingRequest (towerDrawingRequest),
        .shotEnemyCollision  (shotEnemyCollision),
        .shotTowerCollision  (shotTowerCollision),
        .enemyHit            (enemyHit),
        .hitCount            (hitCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add_vec(input logic sof, input logic pse, input logic [2:0] shot,
                           input logic [3:0] enemy, input logic tower,
                           input logic [2:0] se, input logic [2:0] st, input logic [3:0] eh,
                           input logic chk_hc, input logic [7:0] hc);
        vec_t v;
        v.sof = sof; v.pause = pse; v.shot = shot; v.enemy = enemy; v.tower = tower;
        v.exp_se = se; v.exp_st = st; v.exp_eh = eh; v.chk_hc = chk_hc; v.exp_hc = hc;
        vecs.push_back(v);
    endtask

    // Drives one pixel cycle and leaves the bench 1 ns after the capturing edge.
    task automatic apply_stimulus(input logic sof, input logic pse, input logic [2:0] shot,
                                  input logic [3:0] enemy, input logic tower);
        startOfFrame         = sof;
        pause                = pse;
        shotDrawingRequests  = shot;
        enemyDrawingRequests = enemy;
        towerDrawingRequest  = tower;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [2:0] se, input logic [2:0] st,
                                input logic [3:0] eh, input logic chk_hc, input logic [7:0] hc);
        tests_run++;
        if (shotEnemyCollision !== se || shotTowerCollision !== st || enemyHit !== eh ||
            (chk_hc && hitCount !== hc)) begin
            tests_failed++;
            $display("[TB] FAIL %s: got se=%b st=%b hit=%b count=%0d, want se=%b st=%b hit=%b count=%0d",
                     name, shotEnemyCollision, shotTowerCollision, enemyHit, hitCount,
                     se, st, eh, hc);
        end
    endtask

    // One frame in which the given shots hit enemy 0, then one empty frame to re-arm them.
    task automatic hit_then_rearm(input logic [2:0] shots);
        apply_stimulus(1'b0, 1'b0, shots, 4'b0001, 1'b0);
        apply_stimulus(1'b1, 1'b0, 3'b000, 4'b0000, 1'b0);
        apply_stimulus(1'b0, 1'b0, 3'b000, 4'b0000, 1'b0);
        apply_stimulus(1'b1, 1'b0, 3'b000, 4'b0000, 1'b0);
        apply_stimulus(1'b0, 1'b0, 3'b000, 4'b0000, 1'b0);
    endtask

    initial begin
        tests_run            = 0;
        tests_failed         = 0;
        resetN               = 1'b0;
        startOfFrame         = 1'b0;
        pause                = 1'b0;
        shotDrawingRequests  = 3'b000;
        enemyDrawingRequests = 4'b0000;
        towerDrawingRequest  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_state", 3'b000, 3'b000, 4'b0000, 1'b1, 8'd0);
        resetN = 1'b1;

        // sof pause shot enemy tower | se st eh chk_hc hc
        add_vec(0,0,3'b001,4'b0100,0, 3'b000,3'b000,4'b0000,1,8'd0);
        add_vec(1,0,3'b000,4'b0000,0, 3'b000,3'b000,4'b0000,1,8'd0);
        for (int i = 0; i < 5; i++)
            add_vec(0,0,3'b001,4'b0100,0, 3'b000,3'b000,4'b0000,1,8'd0);
        add_vec(1,0,3'b000,4'b0000,0, 3'b001,3'b000,4'b0100,0,8'd0);
        add_vec(0,0,3'b000,4'b0000,0, 3'b000,3'b000,4'b0000,1,8'd1);
        // shot1 hits enemy0 and tower together: enemy wins
        add_vec(0,0,3'b010,4'b0001,1, 3'b000,3'b000,4'b0000,1,8'd1);
        add_vec(0,0,3'b010,4'b0001,1, 3'b000,3'b000,4'b0000,1,8'd1);
        add_vec(1,0,3'b000,4'b0000,0, 3'b010,3'b000,4'b0001,0,8'd0);
        add_vec(0,0,3'b000,4'b0000,0, 3'b000,3'b000,4'b0000,1,8'd2);
        // shot1 disarmed: same overlap reports nothing
        add_vec(0,0,3'b010,4'b0001,1, 3'b000,3'b000,4'b0000,1,8'd2);
        add_vec(1,0,3'b000,4'b0000,0, 3'b000,3'b000,4'b0000,0,8'd0);
        add_vec(0,0,3'b000,4'b0000,0, 3'b000,3'b000,4'b0000,1,8'd2);
        add_vec(0,0,3'b000,4'b0000,0, 3'b000,3'b000,4'b0000,1,8'd2);
        add_vec(1,0,3'b000,4'b0000,0, 3'b000,3'b000,4'b0000,0,8'd0);
        add_vec(0,0,3'b000,4'b0000,0, 3'b000,3'b000,4'b0000,1,8'd2);
        add_vec(0,0,3'b010,4'b0001,0, 3'b000,3'b000,4'b0000,1,8'd2);
        add_vec(1,0,3'b000,4'b0000,0, 3'b010,3'b000,4'b0001,0,8'd0);
        add_vec(0,0,3'b000,4'b0000,0, 3'b000,3'b000,4'b0000,1,8'd3);
        // shot2 tower only, shot0 on two enemies at once
        add_vec(0,0,3'b100,4'b0000,1, 3'b000,3'b000,4'b0000,1,8'd3);
        add_vec(0,0,3'b001,4'b1010,0, 3'b000,3'b000,4'b0000,1,8'd3);
        add_vec(1,0,3'b000,4'b0000,0, 3'b001,3'b100,4'b1010,0,8'd0);
        add_vec(0,0,3'b000,4'b0000,0, 3'b000,3'b000,4'b0000,1,8'd4);
        add_vec(1,0,3'b000,4'b0000,0, 3'b000,3'b000,4'b0000,0,8'd0);
        add_vec(0,0,3'b000,4'b0000,0, 3'b000,3'b000,4'b0000,1,8'd4);
        // paused for a whole frame
        add_vec(0,1,3'b001,4'b0001,0, 3'b000,3'b000,4'b0000,1,8'd4);
        add_vec(1,1,3'b000,4'b0000,0, 3'b000,3'b000,4'b0000,0,8'd0);
        add_vec(0,1,3'b000,4'b0000,0, 3'b000,3'b000,4'b0000,1,8'd4);
        // hit before pause rises is kept, hit during pause dropped; sof in REPORT ignored
        add_vec(0,0,3'b001,4'b0100,0, 3'b000,3'b000,4'b0000,1,8'd4);
        add_vec(0,1,3'b100,4'b0010,0, 3'b000,3'b000,4'b0000,1,8'd4);
        add_vec(1,1,3'b000,4'b0000,0, 3'b001,3'b000,4'b0100,0,8'd0);
        add_vec(1,1,3'b000,4'b0000,0, 3'b000,3'b000,4'b0000,1,8'd5);
        // overlaps only in the SOF and REPORT cycles
        add_vec(0,0,3'b000,4'b0000,0, 3'b000,3'b000,4'b0000,1,8'd5);
        add_vec(1,0,3'b010,4'b0100,0, 3'b000,3'b000,4'b0000,0,8'd0);
        add_vec(0,0,3'b010,4'b0100,1, 3'b000,3'b000,4'b0000,1,8'd5);
        add_vec(0,0,3'b000,4'b0000,0, 3'b000,3'b000,4'b0000,1,8'd5);
        add_vec(1,0,3'b000,4'b0000,0, 3'b000,3'b000,4'b0000,0,8'd0);
        add_vec(0,0,3'b000,4'b0000,0, 3'b000,3'b000,4'b0000,1,8'd5);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].sof, vecs[i].pause, vecs[i].shot, vecs[i].enemy, vecs[i].tower);
            check_output($sformatf("vec%0d", i), vecs[i].exp_se, vecs[i].exp_st,
                         vecs[i].exp_eh, vecs[i].chk_hc, vecs[i].exp_hc);
        end

        // Score saturation
        exp_count = 5;
        for (int f = 0; f < 83; f++) begin
            hit_then_rearm(3'b111);
            exp_count = (exp_count + 3 > 255) ? 255 : exp_count + 3;
        end
        check_output("count_254", 3'b000, 3'b000, 4'b0000, 1'b1, 8'(exp_count));
        apply_stimulus(1'b0, 1'b0, 3'b111, 4'b0001, 1'b0);
        apply_stimulus(1'b1, 1'b0, 3'b000, 4'b0000, 1'b0);
        check_output("sat_report", 3'b111, 3'b000, 4'b0001, 1'b0, 8'd0);
        apply_stimulus(1'b0, 1'b0, 3'b000, 4'b0000, 1'b0);
        check_output("sat_255", 3'b000, 3'b000, 4'b0000, 1'b1, 8'd255);
        apply_stimulus(1'b1, 1'b0, 3'b000, 4'b0000, 1'b0);
        apply_stimulus(1'b0, 1'b0, 3'b000, 4'b0000, 1'b0);
        apply_stimulus(1'b0, 1'b0, 3'b111, 4'b0001, 1'b0);
        apply_stimulus(1'b1, 1'b0, 3'b000, 4'b0000, 1'b0);
        check_output("sat_report2", 3'b111, 3'b000, 4'b0001, 1'b0, 8'd0);
        apply_stimulus(1'b0, 1'b0, 3'b000, 4'b0000, 1'b0);
        check_output("sat_hold", 3'b000, 3'b000, 4'b0000, 1'b1, 8'd255);

        // Overlap then reset before the frame closes
        apply_stimulus(1'b0, 1'b0, 3'b001, 4'b0001, 1'b0);
        resetN = 1'b0;
        #2;
        check_output("reset_mid", 3'b000, 3'b000, 4'b0000, 1'b1, 8'd0);
        @(posedge clk);
        #2;
        resetN = 1'b1;
        apply_stimulus(1'b0, 1'b0, 3'b001, 4'b0001, 1'b0);
        apply_stimulus(1'b1, 1'b0, 3'b000, 4'b0000, 1'b0);
        check_output("first_sof", 3'b000, 3'b000, 4'b0000, 1'b1, 8'd0);
        apply_stimulus(1'b0, 1'b0, 3'b000, 4'b0000, 1'b0);
        apply_stimulus(1'b1, 1'b0, 3'b000, 4'b0000, 1'b0);
        check_output("second_sof", 3'b000, 3'b000, 4'b0000, 1'b1, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
